// File: rtl/instr_seq_pkg.sv
// instr_seq_pkg: shared FSM states, program word field positions and the NOP opcode.
package instr_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int CHK_BIT = 24;
  localparam int INS_HI = 23;
  localparam int INS_LO = 16;
  localparam int EXP_HI = 15;
  localparam int EXP_LO = 0;
  localparam logic [7:0] NOP_INSTR = 8'h00;
endpackage

// File: rtl/instr_rom.sv
// instr_rom: program memory, one synchronous write port and one asynchronous read port.
module instr_rom #(
  parameter int MEMWIDTH = 32,
  parameter int DEPTH = 16,
  parameter int ADDRW = 4
) (
  input  logic                clk,
  input  logic                we_i,
  input  logic [ADDRW-1:0]    waddr_i,
  input  logic [MEMWIDTH-1:0] wdata_i,
  input  logic [ADDRW-1:0]    raddr_i,
  output logic [MEMWIDTH-1:0] rdata_o
);
  logic [MEMWIDTH-1:0] mem_q [DEPTH];
  always_ff @(posedge clk) if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: streams stored instructions to the processor and checks its {PC, ACC} result.
// Define INSTR_SEQ_STOP_ON_ERR_EN to end the run at the first mismatch.
module instr_sequencer
  import instr_seq_pkg::*;
#(
  parameter int MEMWIDTH = 32,
  parameter int DEPTH = 16,
  parameter int ADDRW = 4
) (
  input  logic                clk,
  input  logic                CLB,
  input  logic                load_en,
  input  logic [ADDRW-1:0]    load_addr,
  input  logic [MEMWIDTH-1:0] load_data,
  input  logic [ADDRW:0]      len,
  input  logic                start,
  input  logic [15:0]         proc_out,
  output logic [7:0]          Instruction,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [ADDRW:0]      err_count,
  output logic [ADDRW-1:0]    err_addr
);
  state_e              state_q;
  logic [ADDRW-1:0]    addr_q, err_addr_q;
  logic [ADDRW:0]      err_count_q, len_c;
  logic                first_q, last, mis, go, stop;
  logic [MEMWIDTH-1:0] word;
  logic                unused_bits;
  instr_rom #(.MEMWIDTH(MEMWIDTH), .DEPTH(DEPTH), .ADDRW(ADDRW)) u_rom (
    .clk     (clk),
    .we_i    (load_en && !CLB && state_q != RUN),
    .waddr_i (load_addr),
    .wdata_i (load_data),
    .raddr_i (addr_q),
    .rdata_o (word)
  );
  assign unused_bits = ^word[MEMWIDTH-1:CHK_BIT+1];
  assign len_c = (len > (ADDRW+1)'(DEPTH)) ? (ADDRW+1)'(DEPTH) : len;
  assign last = {1'b0, addr_q} == len_c - (ADDRW+1)'(1);
  assign mis = word[CHK_BIT] && proc_out != word[EXP_HI:EXP_LO];
  assign go = start && len != '0;
`ifdef INSTR_SEQ_STOP_ON_ERR_EN
  assign stop = mis;
`else
  assign stop = 1'b0;
`endif
  assign Instruction = (state_q == RUN) ? word[INS_HI:INS_LO] : NOP_INSTR;
  assign busy = state_q == RUN;
  assign done = state_q == DONE;
  assign pass = state_q == DONE && err_count_q == '0;
  assign err_count = err_count_q;
  assign err_addr = err_addr_q;
  always_ff @(posedge clk) begin
    if (CLB) begin
      state_q <= IDLE;
      addr_q <= '0;
      err_count_q <= '0;
      err_addr_q <= '0;
      first_q <= 1'b0;
    end else if (state_q != RUN) begin
      if (go) begin
        state_q <= RUN;
        addr_q <= '0;
        err_count_q <= '0;
        err_addr_q <= '0;
        first_q <= 1'b0;
      end
    end else begin
      if (mis) begin
        err_count_q <= err_count_q + (ADDRW+1)'(1);
        if (!first_q) begin
          err_addr_q <= addr_q;
          first_q <= 1'b1;
        end
      end
      if (last || stop) state_q <= DONE;
      else addr_q <= addr_q + ADDRW'(1);
    end
  end
endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Synthesizable self-checking instruction source for the `processor` core. It holds a small program memory of `{check, instruction, expected}` words and streams one 8-bit instruction per clock into the processor's `Instruction` input. On every cycle it compares the processor's 16-bit `{PC, ACC}` result against the stored expected value. It sits directly in front of `processor` and lets a board or top-level run a program and report pass/fail without a simulation bench.

## Interface
Parameters:
- `MEMWIDTH`, 32, program word width; layout is `[24]` check, `[23:16]` instruction, `[15:0]` expected.
- `DEPTH`, 16, number of program words.
- `ADDRW`, 4, address width; `DEPTH == 2**ADDRW`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `CLB`  in  1  reset, synchronous, active-high.
- `load_en`  in  1  write strobe for program memory.
- `load_addr`  in  `ADDRW`  write address.
- `load_data`  in  `MEMWIDTH`  write data.
- `len`  in  `ADDRW+1`  number of words to run, 1..`DEPTH`; 0 means `start` is ignored.
- `start`  in  1  single-cycle run request.
- `proc_out`  in  16  processor result `{PC, ACC}`.
- `Instruction`  out  8  instruction to the processor.
- `busy`  out  1  high while in RUN.
- `done`  out  1  high in DONE.
- `pass`  out  1  high in DONE when `err_count == 0`.
- `err_count`  out  `ADDRW+1`  number of mismatches in the current or last run.
- `err_addr`  out  `ADDRW`  address of the first mismatch; 0 if there has been none.

## Operation
- The FSM has three states: IDLE, RUN and DONE.
- IDLE:
  - `start && len != 0` moves to RUN.
  - On that transition: `addr` is set to 0, `err_count` to 0, `err_addr` to 0, and the first-error flag is cleared.
- RUN:
  - `Instruction = mem[addr][23:16]`, driven combinationally from the registered `addr`.
  - At each rising edge, if `mem[addr][24] == 1` and `proc_out != mem[addr][15:0]`, the word is a mismatch.
  - On a mismatch, `err_count` increments. If the first-error flag is clear, `err_addr` is set to `addr` and the flag is set.
  - If `addr == len-1`, the FSM moves to DONE. Otherwise `addr` increments.
  - `mem[addr][24] == 0` means the expected field is don't-care and no compare is made.
- DONE:
  - `start && len != 0` restarts exactly as from IDLE.
  - In every other case the FSM stays in DONE, and all result outputs hold.
- Outside RUN, `Instruction = 8'h00`, which is the NOP.
- `start` is ignored while in RUN.
- Memory writes:
  - `load_en` writes `mem[load_addr] <= load_data` in IDLE or DONE.
  - `load_en` is ignored in RUN, so the program cannot change mid-run.
- `len > DEPTH` is clamped to `DEPTH`.
- `err_count` cannot exceed `DEPTH`, so no saturation logic is needed.

## Timing
- Reset values: state IDLE, `addr` 0, `Instruction` 8'h00, `busy` 0, `done` 0, `pass` 0, `err_count` 0, `err_addr` 0.
- Program memory is not cleared by `CLB`.
- Asserting `CLB` mid-run aborts the run to IDLE on that edge. No result is retained.
- `CLB` has priority over `start` and `load_en`.
- Cycle numbering: the `start` edge is edge 0. Word k is presented from edge k to edge k+1 and compared at edge k+1.
- `busy` is high from edge 0 until edge `len`. `done` rises at edge `len`.
- A write in the same cycle that `start` is accepted is performed, and that write is visible to the run.
- Memory read is asynchronous. Memory write takes effect on the clock edge.

## Configuration
- `INSTR_SEQ_STOP_ON_ERR_EN` defined:
  - The first mismatch moves the FSM to DONE on that edge.
  - `err_count` is then 1, `err_addr` is the failing address, and `pass` is 0.
- Not defined: the run always completes all `len` words and counts every mismatch.

## Structure
- Package `instr_seq_pkg`:
  - state enum `IDLE`/`RUN`/`DONE`;
  - field localparams `CHK_BIT=24`, `INS_HI=23`, `INS_LO=16`, `EXP_HI=15`, `EXP_LO=0`;
  - `NOP_INSTR=8'h00`.
- Sub-module `instr_rom`:
  - `DEPTH` x `MEMWIDTH` register array;
  - one synchronous write port and one asynchronous read port.
- The top level contains the FSM, the counters and the compare logic.

## Test plan
- **Reset:** hold `CLB` for 2 cycles, then release. All outputs stay at their reset values and `Instruction == 8'h00` until `start`.
- **Clean run:** load 4 words with check=1 and expected matching a stub `proc_out` model. Pulse `start` with `len=4`.
  - `Instruction` shows the 4 opcodes on consecutive cycles.
  - `done` and `pass` go high at edge 4; `err_count == 0`.
- **Mismatches:** same program, but corrupt the expected values at addresses 1 and 3.
  - `err_count == 2`, `err_addr == 1`, `pass == 0`.
- **Stop on error:** with `INSTR_SEQ_STOP_ON_ERR_EN` defined, corrupt the expected value at address 2.
  - `done` rises at edge 3.
  - `err_count == 1`, `err_addr == 2`.
- **Don't-care and ignored inputs:** a word with check=0 and a wrong expected value gives no error. `start` with `len=0` stays in IDLE. `load_en` during RUN leaves memory unchanged, verified on a rerun.
- **Abort and restart:** assert `CLB` at word 2.
  - Next cycle is IDLE, `err_count == 0`, `Instruction == 8'h00`.
  - After `start` from DONE, counters clear and the run repeats.
